subleq_mem_arbiter: RTL
=======================

Name: subleq_mem_arbiter

Overview:
- Shares the single-port program/data memory (13-bit word address, 64-bit words, registered read data with 1-cycle latency, write enable) between two requesters.
- Requester 0 is the SUBLEQ core; requester 1 is the host loader/debug port.
- Provides round-robin arbitration, a core lock so one 4-phase instruction (fetch, read A, read B, write) cannot be split by host accesses, and a lock watchdog that stops the core from starving the host.

Parameters:
- AW, 13, memory word-address width
- DW, 64, memory data width
- MAX_LOCK, 16, consecutive locked cycles before forced host slot; 0 disables the watchdog

Ports:
- iClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iCoreReq  in  1  core access request, one access per granted cycle
- iCoreLock  in  1  core requests to keep ownership after this access
- iCoreWe  in  1  core write
- iCoreAddr  in  AW  core address
- iCoreWData  in  DW  core write data
- oCoreGnt  out  1  core access accepted this cycle (combinational)
- oCoreRValid  out  1  core read data valid
- oCoreRData  out  DW  core read data
- iHostReq, iHostWe, iHostAddr, iHostWData  in  1/1/AW/DW  host request, same semantics as the core port, no lock input
- oHostGnt  out  1  host access accepted this cycle
- oHostRValid  out  1  host read data valid
- oHostRData  out  DW  host read data
- oMemAddr  out  AW  memory address
- oMemData  out  DW  memory write data
- oMemWren  out  1  memory write enable
- iMemQ  in  DW  memory registered read data
- oLockBreak  out  1  1-cycle pulse when the watchdog forces a host slot

Behaviour:
- Registered state: mode {OPEN, LOCKED}, rrLast (0=core, 1=host), lockCnt, rdOwner/rdPend.
- Reset values: mode=OPEN, rrLast=host (core wins first tie), lockCnt=0, rdPend=0, oLockBreak=0. All gnt/rvalid are 0 during reset; oMemWren=0 during reset.
- Grant in OPEN mode:
  - Only one requester active: that requester is granted.
  - Both active: the requester other than rrLast is granted.
  - No request: no grant.
- Grant in LOCKED mode: the core is granted whenever iCoreReq=1; oHostGnt=0.
- Any granted cycle:
  - oMemAddr/oMemData/oMemWren are muxed from the winner; oMemWren = winner's We.
  - rrLast is updated to the winner.
  - A granted read sets rdPend=1 and rdOwner=winner for the next cycle.
- No grant: oMemAddr holds its last value; oMemWren=0.
- Read return: the cycle after a granted read, the owner's RValid=1 and RData=iMemQ. The other port's RValid=0. RData values are don't-care when RValid=0, but must be driven from iMemQ.
- Writes produce no RValid.
- A read and a write to the same address in consecutive grants return the old data (memory read-before-write).
- LOCKED entry: core granted with iCoreLock=1 → mode=LOCKED next cycle.
- LOCKED exit, any of the following → OPEN next cycle:
  - core granted with iCoreLock=0;
  - iCoreReq=0 while LOCKED;
  - watchdog fires.
- Watchdog:
  - lockCnt increments on each LOCKED cycle and clears in OPEN.
  - When lockCnt reaches MAX_LOCK and iHostReq=1: that cycle the host is granted instead of the core, oLockBreak=1, lockCnt is cleared, and mode stays LOCKED. The core is then re-granted on the following cycles.
  - When lockCnt reaches MAX_LOCK with no host request, lockCnt saturates and no break occurs.
- Reset mid-operation: a pending read return is dropped (no RValid after reset); the lock is released.
- A requester must hold Req/We/Addr/WData stable until it sees Gnt.

Optional Feature:
- Macro: SUBLEQ_ARB_STATS_EN.
- Enabled, adds the following output ports, all reset to 0 and wrapping at 2^32:
  - oCoreGrants[31:0]: count of core grants.
  - oHostGrants[31:0]: count of host grants.
  - oHostStall[31:0]: count of cycles with iHostReq=1 and oHostGnt=0.
- Disabled: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then core read addr 5 (memory holds 0x1234) → oCoreGnt=1 same cycle; next cycle oCoreRValid=1, oCoreRData=0x1234; oHostRValid=0.
- Both request continuously, no lock, both reading → grants alternate core, host, core, host; first grant goes to core.
- Core locks for 4 accesses (lock=1,1,1,0) while host requests throughout → host granted only in the cycle after the lock=0 access; host write of 0x55 to addr 7 lands in memory after the core's 4th access.
- MAX_LOCK=16, core holds lock for 40 cycles, host requests → oLockBreak pulses at locked cycles 16 and 33, host granted exactly those cycles, core granted all others.
- Reset asserted the cycle after a granted core read with lock=1 → no oCoreRValid; after release, a host request is granted immediately (mode OPEN).
- With SUBLEQ_ARB_STATS_EN, 10 host requests during 6 locked core cycles then open → oHostStall=6, oHostGrants=10, oCoreGrants=6.

Source files
------------

// File: rtl/subleq_mem_arbiter.sv
// subleq_mem_arbiter: shares one single-port memory (registered read data,
// 1-cycle latency) between the SUBLEQ core (requester 0) and the host
// loader/debug port (requester 1).
//   - Round-robin arbitration while OPEN.
//   - The core can lock the memory so one instruction's accesses stay together.
//   - A lock watchdog hands the host one slot after MAX_LOCK locked cycles.
// Handshake: a requester holds Req/We/Addr/WData stable until it sees Gnt in
// the same cycle; a granted read returns RValid/RData exactly one cycle later.
// Optional build macro SUBLEQ_ARB_STATS_EN adds grant/stall counters.
module subleq_mem_arbiter #(
    parameter int AW       = 13,
    parameter int DW       = 64,
    parameter int MAX_LOCK = 16
) (
    input  logic          iClock,
    input  logic          iReset,
    input  logic          iCoreReq,
    input  logic          iCoreLock,
    input  logic          iCoreWe,
    input  logic [AW-1:0] iCoreAddr,
    input  logic [DW-1:0] iCoreWData,
    output logic          oCoreGnt,
    output logic          oCoreRValid,
    output logic [DW-1:0] oCoreRData,
    input  logic          iHostReq,
    input  logic          iHostWe,
    input  logic [AW-1:0] iHostAddr,
    input  logic [DW-1:0] iHostWData,
    output logic          oHostGnt,
    output logic          oHostRValid,
    output logic [DW-1:0] oHostRData,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    output logic          oMemWren,
    input  logic [DW-1:0] iMemQ,
    output logic          oLockBreak
`ifdef SUBLEQ_ARB_STATS_EN
   ,output logic [31:0]   oCoreGrants,
    output logic [31:0]   oHostGrants,
    output logic [31:0]   oHostStall
`endif
);

    localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic {MODE_OPEN, MODE_LOCKED} mode_t;

    mode_t         mode_q, mode_d;
    logic          rr_last_q, rr_last_d;      // 1 = host won last
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;    // 1 = host owns pending read
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic core_win, host_win, any_gnt, watchdog_fire, win_we;

`ifdef SUBLEQ_ARB_STATS_EN
    logic [31:0] core_grants_q, core_grants_d;
    logic [31:0] host_grants_q, host_grants_d;
    logic [31:0] host_stall_q, host_stall_d;
`endif

    // Arbitration, memory mux, lock/watchdog and read-return next state
    always_comb begin
        watchdog_fire = 1'b0;
        core_win      = 1'b0;
        host_win      = 1'b0;
        if (mode_q == MODE_LOCKED) begin
            watchdog_fire = (MAX_LOCK != 0) && (lock_cnt_q == LOCK_MAX) && iHostReq;
            core_win      = iCoreReq && !watchdog_fire;
            host_win      = watchdog_fire;
        end else begin
            core_win = iCoreReq && (!iHostReq || rr_last_q);
            host_win = iHostReq && !core_win;
        end
        // Nothing is accepted while reset is held.
        core_win      = core_win && !iReset;
        host_win      = host_win && !iReset;
        watchdog_fire = watchdog_fire && !iReset;
        any_gnt       = core_win || host_win;
        win_we        = host_win ? iHostWe : iCoreWe;

        oCoreGnt   = core_win;
        oHostGnt   = host_win;
        oLockBreak = watchdog_fire;
        oMemData   = host_win ? iHostWData : iCoreWData;
        oMemWren   = any_gnt && win_we;
        mem_addr_d = any_gnt ? (host_win ? iHostAddr : iCoreAddr) : mem_addr_q;
        oMemAddr   = mem_addr_d;

        oCoreRValid = rd_pend_q && !rd_owner_q && !iReset;
        oHostRValid = rd_pend_q &&  rd_owner_q && !iReset;
        oCoreRData  = iMemQ;
        oHostRData  = iMemQ;

        rr_last_d  = any_gnt ? host_win : rr_last_q;
        rd_pend_d  = any_gnt && !win_we;
        rd_owner_d = any_gnt ? host_win : rd_owner_q;

        // Lock state: a break keeps the lock; otherwise the core must keep
        // requesting with lock set to stay LOCKED.
        mode_d = mode_q;
        if (mode_q == MODE_LOCKED) begin
            if (!watchdog_fire && (!iCoreReq || !iCoreLock))
                mode_d = MODE_OPEN;
        end else if (core_win && iCoreLock) begin
            mode_d = MODE_LOCKED;
        end

        // Counter advances for every cycle that ends LOCKED, saturating.
        lock_cnt_d = '0;
        if (mode_d == MODE_LOCKED && !watchdog_fire)
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + CW'(1);

`ifdef SUBLEQ_ARB_STATS_EN
        core_grants_d = core_grants_q + (core_win ? 32'd1 : 32'd0);
        host_grants_d = host_grants_q + (host_win ? 32'd1 : 32'd0);
        host_stall_d  = host_stall_q + ((iHostReq && !host_win) ? 32'd1 : 32'd0);
        oCoreGrants   = core_grants_q;
        oHostGrants   = host_grants_q;
        oHostStall    = host_stall_q;
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge iClock) begin
        if (iReset) begin
            mode_q     <= MODE_OPEN;
            rr_last_q  <= 1'b1;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            mem_addr_q <= '0;
`ifdef SUBLEQ_ARB_STATS_EN
            core_grants_q <= '0;
            host_grants_q <= '0;
            host_stall_q  <= '0;
`endif
        end else begin
            mode_q     <= mode_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            mem_addr_q <= mem_addr_d;
`ifdef SUBLEQ_ARB_STATS_EN
            core_grants_q <= core_grants_d;
            host_grants_q <= host_grants_d;
            host_stall_q  <= host_stall_d;
`endif
        end
    end

endmodule
